nano_dsi_data: RTL and testbench
================================

Name: nano_dsi_data

Overview:
- Single DSI data-lane transmitter for the nano-PMOD. Sits alongside the clock-lane block.
- Consumes the clock lane's `clk_sync` phase and an "HS clock running" indication.
- Accepts a byte stream from the upstream packet builder.
- Performs the LP11→LP00→HS-zero→sync→data→trail→LP11 sequence, serialising one bit per `clk` cycle, LSB first, through SB_IO drivers.

Parameters:
- SYNC_BYTE, 8'hB8, HS leader byte sent before the first data byte.
- HS_NEG_TRIGGER, 1'b1, HS pads clocked on the falling `clk` edge so data sits half a bit off the clock-lane edges.

Ports:
- clk  input  1  system/bit clock (one HS bit per cycle)
- rst  input  1  synchronous, active-high reset
- data_lp  output  1  LP bias pin (SB_IO registered output, 1 = LP11)
- data_hs_p  output  1  HS driver P (SB_IO registered, tristate via OE)
- data_hs_n  output  1  HS driver N (always complement of P)
- clk_hs_rdy  input  1  clock lane is in continuous HS clock state
- clk_sync  input  1  clock-lane phase toggle
- in_data  input  8  byte to send
- in_last  input  1  marks final byte of burst
- in_valid  input  1  byte available
- in_ready  output  1  one-cycle pulse: `in_data` consumed this cycle
- busy  output  1  lane not in LP11
- err_underrun  output  1  one-cycle pulse on a starved byte slot
- cfg_lpx  input  8  minimum LP11 dwell between bursts
- cfg_hs_prep  input  8  LP00 duration
- cfg_hs_zero  input  8  HS-zero duration
- cfg_hs_trail  input  8  HS-trail duration

Behaviour:
- **Reset.** rst is synchronous, active-high; clock is `clk`. Reset forces:
  - state LP11, with the LP11 timer loaded from `cfg_lpx`;
  - `data_lp`=1, HS OE=0, `in_ready`=0, `busy`=0, `err_underrun`=0.
  - Reset mid-burst aborts immediately; the pads are back at LP11/tristate one cycle later (IOB register).
- **Timer.** 8-bit down counter, preloaded on every state change; trig = `timer[7]`.
  - A state with config value N (0..127) lasts exactly N+2 cycles.
  - Config values ≥128 give a 1-cycle state (trig immediately).
  - Config inputs are sampled only at preload.
- **States.**
  - LP11: leave to LP00 when timer trig AND `in_valid` AND `clk_hs_rdy`.
  - LP00: `data_lp`=0, OE=0. Leave to HS_ZERO on trig.
  - HS_ZERO: OE=1, bit=0. Leave on trig AND `clk_sync`=0, so the sync byte starts on a fixed clock phase.
  - HS_SYNC: shift out SYNC_BYTE LSB first, 8 cycles, then HS_DATA.
  - HS_DATA: 8 cycles per byte, LSB first.
  - HS_TRAIL: OE=1, bit = complement of the last transmitted bit, held. On trig go to LP11, preloading `cfg_lpx`.
- **Byte loading.**
  - Bit counter is 3 bits; a load slot occurs when it wraps (last bit of SYNC or of a data byte).
  - At a load slot with `in_valid`=1: `in_ready` pulses, `in_data` enters the shift register, and `in_last` is latched.
  - `in_ready` is asserted only at load slots. The upstream block must hold `in_valid`/`in_data` until it sees `in_ready`.
- **End of burst.**
  - After a byte with `in_last`=1 has been fully shifted, go to HS_TRAIL; no `in_ready` in that slot.
  - At a load slot with `in_valid`=0 and no latched last: `err_underrun` pulses, then go to HS_TRAIL (burst truncated cleanly).
- **Loss of clock lane.** `clk_hs_rdy` dropping during LP00..HS_DATA also goes to HS_TRAIL, with `err_underrun`.
- **Output timing.**
  - `data_lp`, OE and HS bit are registered in fabric and again in the IOB.
  - Pad output lags the state by 2 cycles, equal to the clock-lane latency.
  - `busy` = state≠LP11, combinational from the state register.
- **Pads.**
  - HS pads: PIN_TYPE registered output with registered OE; `D_OUT_0`=`D_OUT_1`=bit (N side inverted); NEG_TRIGGER=HS_NEG_TRIGGER.
  - LP pad: registered, always enabled.

Decomposition:
- Shared package `nano_dsi_pkg`:
  - state encodings for the LP/HS sequence (shared with the clock lane);
  - timer width and trig-bit constants;
  - SYNC_BYTE default.
- One natural sub-module: `nano_dsi_timer` (preload/decrement/bit-7 trig). It is reusable by the clock lane.
- The serializer stays inline.

Test Plan:
- **Single byte.** `cfg_lpx`=0, prep=3, zero=5, trail=4; send 0xA5 with last. Required: LP00 lasts 5 cycles; HS-zero ≥7 cycles; pad bits 0,0,0,1,1,1,0,1 then 1,0,1,0,0,1,0,1; trail holds 0 for 6 cycles; then LP11; exactly one `in_ready`.
- **4-byte burst, `in_valid` always high.** Required: `in_ready` pulses exactly 8 cycles apart; bit stream is contiguous; `busy` is low only after trail.
- **Underrun.** Drop `in_valid` before byte 2's slot. Required: `err_underrun` for 1 cycle at that slot; 1 byte sent; trail follows.
- **`clk_hs_rdy`=0 with `in_valid`=1.** Required: lane stays LP11, `busy`=0; once ready rises, start within `cfg_lpx`+2 cycles.
- **Reset mid-HS_DATA.** Required: next cycle state LP11, `in_ready`=0; pads are `data_lp`=1 with OE=0 two cycles after reset asserts.
- **Back-to-back bursts, `cfg_lpx`=10.** Required: ≥12 cycles of LP11 between trail end and the next LP00.

Source files
------------

// File: rtl/nano_dsi_pkg.sv
// ---------------------------------------------------------------------------
// nano_dsi_pkg : lane state encodings, timer constants, timer preload select
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nano_dsi_pkg;

  localparam int          TIMER_W           = 8;
  localparam int          TRIG_BIT          = 7;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hB8;

  typedef enum logic [2:0] {
    ST_LP11     = 3'd0,
    ST_LP00     = 3'd1,
    ST_HS_ZERO  = 3'd2,
    ST_HS_SYNC  = 3'd3,
    ST_HS_DATA  = 3'd4,
    ST_HS_TRAIL = 3'd5
  } lane_state_t;

  // Dwell value loaded into the timer when the lane enters state s.
  function automatic logic [TIMER_W-1:0] preload_for(
    input lane_state_t        s,
    input logic [TIMER_W-1:0] lpx,
    input logic [TIMER_W-1:0] prep,
    input logic [TIMER_W-1:0] zero,
    input logic [TIMER_W-1:0] trail
  );
    logic [TIMER_W-1:0] val;
    case (s)
      ST_LP11:     val = lpx;
      ST_LP00:     val = prep;
      ST_HS_ZERO:  val = zero;
      ST_HS_TRAIL: val = trail;
      default:     val = '0;
    endcase
    return val;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nano_dsi_timer.sv
// ---------------------------------------------------------------------------
// nano_dsi_timer : preloadable down counter, trig = MSB, holds once expired
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nano_dsi_timer
  import nano_dsi_pkg::*;
(
  input  logic               clk,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               trig
);

  logic [TIMER_W-1:0] count;

  // Stop at the first expired value so trig stays high while the FSM waits.
  always_ff @(posedge clk) begin
    if (load)
      count <= load_val;
    else if (!count[TRIG_BIT])
      count <= count - 1'b1;
  end

  assign trig = count[TRIG_BIT];

endmodule

`default_nettype wire

// File: rtl/nano_dsi_data.sv
// ---------------------------------------------------------------------------
// nano_dsi_data : DSI data-lane LP/HS sequencer and LSB-first serializer
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nano_dsi_data
  import nano_dsi_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter bit         HS_NEG_TRIGGER = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       data_lp,
  output logic       data_hs_p,
  output logic       data_hs_n,
  input  logic       clk_hs_rdy,
  input  logic       clk_sync,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       busy,
  output logic       err_underrun,
  input  logic [7:0] cfg_lpx,
  input  logic [7:0] cfg_hs_prep,
  input  logic [7:0] cfg_hs_zero,
  input  logic [7:0] cfg_hs_trail
);

  lane_state_t        state, state_nxt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               last_latched, last_bit;
  logic               trig, timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               take_byte, underrun, hs_lost, hs_bit;
  logic               lp_fab, oe_fab, bit_fab;
  logic               lp_iob, oe_iob, bit_iob;

  assign timer_load = rst || (state_nxt != state);
  assign timer_val  = rst ? cfg_lpx
                          : preload_for(state_nxt, cfg_lpx, cfg_hs_prep, cfg_hs_zero, cfg_hs_trail);

  nano_dsi_timer u_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_val),
    .trig     (trig)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LP11;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_byte = 1'b0;
    underrun  = 1'b0;
    hs_lost   = !clk_hs_rdy && (state inside {ST_LP00, ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA});
    case (state)
      ST_LP11:     if (trig && in_valid && clk_hs_rdy) state_nxt = ST_LP00;
      ST_LP00:     if (trig) state_nxt = ST_HS_ZERO;
      ST_HS_ZERO:  if (trig && !clk_sync) state_nxt = ST_HS_SYNC;
      ST_HS_SYNC,
      ST_HS_DATA: begin
        if (bit_cnt == 3'd7) begin
          if (last_latched) begin
            state_nxt = ST_HS_TRAIL;
          end else if (in_valid) begin
            take_byte = 1'b1;
            state_nxt = ST_HS_DATA;
          end else begin
            underrun  = 1'b1;
            state_nxt = ST_HS_TRAIL;
          end
        end
      end
      ST_HS_TRAIL: if (trig) state_nxt = ST_LP11;
      default:     state_nxt = ST_LP11;
    endcase
    if (hs_lost) begin
      state_nxt = ST_HS_TRAIL;
      take_byte = 1'b0;
      underrun  = 1'b1;
    end
  end

  always_comb begin
    hs_bit = 1'b0;
    case (state)
      ST_HS_SYNC, ST_HS_DATA: hs_bit = shreg[0];
      ST_HS_TRAIL:            hs_bit = ~last_bit;
      default:                hs_bit = 1'b0;
    endcase
  end

  // HS-zero keeps the shifter primed with the leader byte for the sync slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      last_latched <= 1'b0;
      last_bit     <= 1'b0;
    end else begin
      if (state == ST_HS_ZERO) begin
        bit_cnt      <= 3'd0;
        shreg        <= SYNC_BYTE;
        last_latched <= 1'b0;
      end else if (state inside {ST_HS_SYNC, ST_HS_DATA}) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (take_byte) begin
          shreg        <= in_data;
          last_latched <= in_last;
        end else begin
          shreg <= {1'b0, shreg[7:1]};
        end
      end
      if (state == ST_LP00)
        last_bit <= 1'b0;
      else if (state inside {ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA})
        last_bit <= hs_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_fab  <= 1'b1;
      oe_fab  <= 1'b0;
      bit_fab <= 1'b0;
    end else begin
      lp_fab  <= (state == ST_LP11);
      oe_fab  <= (state inside {ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL});
      bit_fab <= hs_bit;
    end
  end

  // IOB output registers; the HS pair may launch on the falling edge.
  always_ff @(posedge clk) lp_iob <= lp_fab;

  generate
    if (HS_NEG_TRIGGER) begin : g_hs_neg
      always_ff @(negedge clk) begin
        oe_iob  <= oe_fab;
        bit_iob <= bit_fab;
      end
    end else begin : g_hs_pos
      always_ff @(posedge clk) begin
        oe_iob  <= oe_fab;
        bit_iob <= bit_fab;
      end
    end
  endgenerate

  assign data_lp      = lp_iob;
  assign data_hs_p    = oe_iob ? bit_iob  : 1'bz;
  assign data_hs_n    = oe_iob ? ~bit_iob : 1'bz;
  assign busy         = (state != ST_LP11);
  assign in_ready     = take_byte && !rst;
  assign err_underrun = underrun && !rst;

endmodule

`default_nettype wire

// File: tb/tb_nano_dsi_data.sv
// ---------------------------------------------------------------------------
// tb_nano_dsi_data : randomized and directed bench; pad traces are decoded
// against burst descriptions (dwell times, bit stream, handshake counts).
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nano_dsi_data;

  localparam int         TMAX   = 4096;
  localparam logic [7:0] SYNC_B = 8'hB8;

  logic       clk = 1'b0, rst = 1'b1;
  logic       clk_hs_rdy = 1'b1, clk_sync = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0, in_valid = 1'b0;
  logic [7:0] cfg_lpx = 8'd0, cfg_hs_prep = 8'd3, cfg_hs_zero = 8'd5, cfg_hs_trail = 8'd4;
  wire        data_lp, data_hs_p, data_hs_n, in_ready, busy, err_underrun;
  wire        pad_oe;

  nano_dsi_data dut (
    .clk(clk), .rst(rst), .data_lp(data_lp), .data_hs_p(data_hs_p), .data_hs_n(data_hs_n),
    .clk_hs_rdy(clk_hs_rdy), .clk_sync(clk_sync), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .err_underrun(err_underrun),
    .cfg_lpx(cfg_lpx), .cfg_hs_prep(cfg_hs_prep), .cfg_hs_zero(cfg_hs_zero),
    .cfg_hs_trail(cfg_hs_trail)
  );

  assign pad_oe = dut.oe_iob;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk); #1;
    clk_sync = ~clk_sync;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Source and burst description
  logic [7:0] src_bytes[$];
  bit         src_last[$];
  int         src_idx = 0, n_offer = 0;
  bit         rdy_seen = 0;
  logic [7:0] exp_bytes[$];
  int         exp_n[$];

  // Trace, sampled 4 ns after each rising edge
  bit lp_t[TMAX], oe_t[TMAX], p_t[TMAX], n_t[TMAX], busy_t[TMAX], rdy_t[TMAX], err_t[TMAX];
  int tlen = 0;

  function automatic int cyc(input logic [7:0] v);
    return (v >= 8'd128) ? 1 : int'(v) + 2;
  endfunction

  task automatic clear_run();
    src_bytes.delete(); src_last.delete(); exp_bytes.delete(); exp_n.delete();
    src_idx = 0; n_offer = 0; rdy_seen = 0;
  endtask

  task automatic add_burst(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      src_bytes.push_back(b); src_last.push_back(i == n - 1); exp_bytes.push_back(b);
    end
    exp_n.push_back(n);
    n_offer = src_bytes.size();
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (rdy_seen) src_idx++;
    if (src_idx < n_offer) begin
      in_valid = 1'b1; in_data = src_bytes[src_idx]; in_last = src_last[src_idx];
    end else begin
      in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    end
    #3;
    rdy_seen = in_ready;
    if (tlen < TMAX) begin
      lp_t[tlen] = data_lp; oe_t[tlen] = pad_oe; p_t[tlen] = data_hs_p; n_t[tlen] = data_hs_n;
      busy_t[tlen] = busy; rdy_t[tlen] = in_ready; err_t[tlen] = err_underrun;
      tlen++;
    end
  endtask

  task automatic record_run();
    int idle, cnt;
    tlen = 0; idle = 0; cnt = 0;
    while (idle < 6 && cnt < 3000) begin
      step(); cnt++;
      if (src_idx >= n_offer && !busy && data_lp) idle++;
      else idle = 0;
    end
    check("run_timeout", int'(cnt >= 3000), 0);
  endtask

  task automatic analyse(input int exp_err);
    int c, s, b, base, L, T, Z, zmin, mism, nmism, n, k, e, falls, errs, bm;
    logic [7:0] sb;
    bit lastb;
    int rq[$], bid[$];
    sb = SYNC_B; c = 0; b = 0; base = 0;
    while (b < exp_n.size() && c < tlen) begin
      s = c; while (c < tlen && lp_t[c]) c++;
      if (b > 0) check("lp11_dwell", c - s, cyc(cfg_lpx));
      s = c; while (c < tlen && !lp_t[c] && !oe_t[c]) c++;
      check("lp00_len", c - s, cyc(cfg_hs_prep));
      s = c; while (c < tlen && oe_t[c]) c++;
      L = c - s; n = exp_n[b]; T = cyc(cfg_hs_trail); zmin = cyc(cfg_hs_zero);
      Z = L - T - 8 - 8 * n;
      check("hs_zero_len_ok", int'(Z >= zmin && Z <= zmin + 1), 1);
      lastb = (n > 0) ? exp_bytes[base + n - 1][7] : sb[7];
      mism = 0; nmism = 0;
      if (Z < 0) mism = -1;
      else begin
        for (int i = 0; i < L; i++) begin
          k = i - Z;
          if (i < Z)               e = 0;
          else if (k < 8)          e = int'(sb[k]);
          else if (k < 8 + 8 * n)  e = int'(exp_bytes[base + (k - 8) / 8][(k - 8) % 8]);
          else                     e = int'(!lastb);
          if (int'(p_t[s + i]) != e) mism++;
          if (n_t[s + i] == p_t[s + i]) nmism++;
        end
      end
      check("hs_bits", mism, 0);
      check("hs_n_complement", nmism, 0);
      base += n; b++;
    end
    falls = 0; errs = 0; bm = 0;
    for (int i = 0; i < tlen; i++) begin
      if (i > 0 && lp_t[i - 1] && !lp_t[i]) falls++;
      if (rdy_t[i]) rq.push_back(i);
      if (err_t[i]) errs++;
      if (i + 2 < tlen && busy_t[i] != !lp_t[i + 2]) bm++;
    end
    check("bursts", falls, exp_n.size());
    check("ready_count", rq.size(), exp_bytes.size());
    check("underrun_count", errs, exp_err);
    check("busy_vs_pad", bm, 0);
    foreach (exp_n[j]) for (int i = 0; i < exp_n[j]; i++) bid.push_back(j);
    for (int j = 1; j < rq.size() && j < bid.size(); j++)
      if (bid[j] == bid[j - 1]) check("ready_gap", rq[j] - rq[j - 1], 8);
  endtask

  task automatic set_cfg(input int lpx, input int prep, input int zero, input int trail);
    cfg_lpx = 8'(lpx); cfg_hs_prep = 8'(prep); cfg_hs_zero = 8'(zero); cfg_hs_trail = 8'(trail);
  endtask

  int first;

  initial begin
    // Reset
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_err", int'(err_underrun), 0);
    check("rst_lp_pad", int'(data_lp), 1);
    check("rst_oe_pad", int'(pad_oe), 0);

    // Single byte 0xA5 with last
    set_cfg(0, 3, 5, 4); clear_run();
    src_bytes.push_back(8'hA5); src_last.push_back(1'b1); exp_bytes.push_back(8'hA5);
    exp_n.push_back(1); n_offer = 1;
    record_run(); analyse(0);

    // 4-byte burst, valid always high
    clear_run(); add_burst(4); record_run(); analyse(0);

    // Underrun at byte 2's slot
    clear_run();
    src_bytes.push_back(8'h3C); src_last.push_back(1'b0); exp_bytes.push_back(8'h3C);
    src_bytes.push_back(8'hC3); src_last.push_back(1'b1);
    exp_n.push_back(1); n_offer = 1;
    record_run(); analyse(1);

    // Clock lane not ready: lane must stay in LP11
    set_cfg(3, 2, 2, 2); clear_run(); add_burst(1);
    clk_hs_rdy = 1'b0;
    first = 0;
    repeat (20) begin step(); if (busy || !data_lp) first++; end
    check("no_start_without_clk", first, 0);
    clk_hs_rdy = 1'b1;
    record_run();
    first = -1;
    for (int i = tlen - 1; i >= 0; i--) if (busy_t[i]) first = i;
    check("start_after_clk_rdy", int'(first >= 0 && first <= int'(cfg_lpx) + 2), 1);
    analyse(0);

    // Reset in the middle of HS data
    set_cfg(0, 1, 1, 1); clear_run(); add_burst(4);
    first = 0;
    while (!rdy_seen && first < 200) begin step(); first++; end
    check("mid_rst_reach_data", int'(first < 200), 1);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    step();
    check("mid_rst_lp_pad", int'(data_lp), 1);
    check("mid_rst_oe_pad", int'(pad_oe), 0);
    rst = 1'b0; n_offer = 0;
    repeat (8) step();

    // Back-to-back bursts with lpx = 10
    set_cfg(10, 2, 3, 2); clear_run(); add_burst(3); add_burst(2);
    record_run(); analyse(0);

    // Randomized configurations and bursts
    for (int it = 0; it < 6; it++) begin
      set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      if (it == 4) cfg_hs_prep = 8'd130;
      if (it == 5) cfg_hs_trail = 8'd200;
      clear_run();
      for (int j = 0; j < 1 + int'($urandom_range(0, 1)); j++) add_burst($urandom_range(1, 4));
      record_run(); analyse(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
